hazard_tracker: RTL and testbench
=================================

# hazard_tracker

Initiator side of `hazard_interface`. It keeps a shadow pipeline of the hazard-relevant metadata for each instruction: rs1, rs2, rd, regwrite and memaccess. The D-stage fields come straight from the decoder; the E, M and W stages are registers inside this block. It drives `hazard_bus.req` from that shadow pipeline and applies the returned stall and flush controls to its own stage registers. It sits between the decode stage and the hazard completer, and re-exports the completer's forwarding, stall and flush controls to the datapath.

## Interface
Parameters:
- `REG_AW`, default 5: register-address width.
- `CNT_W`, default 32: performance-counter width (used only when the counter feature is compiled in).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  system clock.
  - `reset`  in  1  asynchronous, active-high reset.
- Pipeline run control:
  - `start`  in  1  pipeline run enable; while low, the shadow pipeline is held empty.
- Decode-stage fields (combinational from the decode stage):
  - `rs1_d`, `rs2_d`  in  REG_AW each  source register addresses.
  - `rd_d`  in  REG_AW  destination register address.
  - `regwrite_d`  in  1  instruction writes rd.
  - `memaccess_d`  in  2  `memaccess_t` value.
  - `valid_d`  in  1  D holds a real instruction.
- Other inputs:
  - `pcsrc_e`  in  1  branch or jump taken, resolved in E.
  - `flushflag`  in  1  trap or redirect flush of all stages.
- Bus:
  - `hazard_bus`  `hazard_interface.initiator`  drives `req`, consumes `res`.
- Outputs to the datapath:
  - `forward_a_e`, `forward_b_e`  out  2 each  forwarding selects for the E-stage operands.
  - `forward_mem_m`  out  1  store-data forward select in M.
  - `stall_f`, `stall_d`  out  1 each  fetch and decode stalls.
  - `flush_d`, `flush_e`, `flush_m`  out  1 each  per-stage flushes.
- Counters (present only with `HAZARD_PERF_EN`):
  - `cnt_raw`, `cnt_store`, `cnt_loaduse`, `cnt_mispredict`  out  CNT_W each.

## Operation
- **Stage registers.** E, M and W each hold one `hazard_meta_t`. The empty value is `HAZARD_BUBBLE`: every field is zero and memaccess is `MEM_NONE`.
- **Capture into E.**
  - E captures `{rs1_d, rs2_d, rd_d, regwrite_d & valid_d & (rd_d != 0), valid_d ? memaccess_d : MEM_NONE}`.
  - Because of this qualification, x0 is never a forwarding source.
- **Update order, evaluated each rising edge in this priority:**
  - `!start`: E, M and W all take the bubble value.
  - `res.flush_e`: E takes the bubble. This covers both load-use and mispredict.
  - Otherwise, E captures the qualified D fields.
  - M takes the bubble if `res.flush_m`; otherwise M takes E.
  - W always takes M.
- **No stage holding.** `stall_d` never holds E. A load-use stall is realised by flushing E while D is frozen upstream.
- **Request fields driven onto `hazard_bus.req`:**
  - D fields, combinational pass-through: `rs1_d`, `rs2_d`.
  - From E: `rs1_e`, `rs2_e`, `rd_e`, `memaccess_e`.
  - From M: `rd_m`, `rs2_m`, `regwrite_m`, `memaccess_m`.
  - From W: `rd_w`, `regwrite_w`.
  - Pass-through inputs: `pcsrc = pcsrc_e`, `flushflag = flushflag`.
- **Response re-export.** All `res` controls are re-exported combinationally to the matching outputs.
- **Simultaneous events.**
  - `flushflag` together with load-use: E and M both become bubbles; flushflag wins.
  - Mispredict together with load-use: E becomes a bubble once; stall is still reported for that cycle.

## Timing
- **Reset values.**
  - Stage registers reset to the bubble value.
  - All outputs derived from the stage registers are therefore 0 after reset.
  - All counters reset to 0.
- **Latency.** Metadata in D at cycle n appears as `*_e` at n+1, `*_m` at n+2 and `*_w` at n+3, provided there is no flush.
- **Combinational paths.** D fields through `req` to `res` and back to the outputs form a pure combinational path with zero cycles of latency. The block adds no registers on `res`.
- **Reset mid-operation.** Asynchronous reset clears all stages immediately. The first capture happens on the first edge after reset deasserts with `start=1`.
- **Counters.** Each `hazard_cause` flag increments its counter by 1 per cycle while `start=1`. Counters wrap modulo 2^CNT_W.

## Configuration
- `HAZARD_PERF_EN` defined: the four cause counters and their output ports are compiled in.
- `HAZARD_PERF_EN` undefined: counters and ports are absent; the rest of the behaviour is identical.

## Structure
- `riscv_defines` package:
  - `memaccess_t` enum: `MEM_NONE=0`, `MEM_LOAD=1`, `MEM_STORE=2`.
  - `hazard_meta_t` packed struct.
  - `HAZARD_BUBBLE` constant.
- Sub-module `hazard_stage_reg`: one metadata register with async reset and a synchronous flush-to-bubble. It is instantiated three times.

## Test plan
- **Reset.** Assert reset with `start=0`, release, then set `start=1` → all `req` E/M/W fields are 0 and all counters are 0.
- **RAW hazard, E source.** D: `rd=5`, regwrite. Next D: `rs1=5` → `rd_m=5` while `rs1_e=5`, and `forward_a_e` selects M. `cnt_raw` increments by 1.
- **Load-use.** D: load `rd=7`. Next D: `rs2=7` → `stall_f=stall_d=1` for 1 cycle and E becomes a bubble (`rd_e=0`). On the following cycle the dependent instruction enters E with `rs2_e=7`.
- **Mispredict.** `pcsrc_e=1` → `flush_d` and `flush_e` are asserted. On the next cycle `rd_e=0` and `memaccess_e=MEM_NONE`, and `cnt_mispredict` is 1.
- **x0 destination.** D: `rd=0`, `regwrite_d=1` → captured `regwrite` is 0. A later `rs1=0` produces no forwarding.
- **Flush priority.** `flushflag=1` in the same cycle as a load-use → E and M are bubbles on the next cycle, and W takes the old M.

Source files
------------

// File: rtl/riscv_defines_pkg.sv
// Shared pipeline-hazard types: memory-access kinds, per-stage metadata,
// and the request/response payloads carried by hazard_interface.
package riscv_defines;

    localparam int HAZARD_REG_AW = 5;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } memaccess_t;

    // Operand forwarding selects used by the E-stage muxes
    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_W    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;

    typedef struct packed {
        logic [HAZARD_REG_AW-1:0] rs1;
        logic [HAZARD_REG_AW-1:0] rs2;
        logic [HAZARD_REG_AW-1:0] rd;
        logic                     regwrite;
        memaccess_t               memaccess;
    } hazard_meta_t;

    localparam hazard_meta_t HAZARD_BUBBLE = '0;

    typedef struct packed {
        logic raw;
        logic store;
        logic loaduse;
        logic mispredict;
    } hazard_cause_t;

    typedef struct packed {
        logic [HAZARD_REG_AW-1:0] rs1_d;
        logic [HAZARD_REG_AW-1:0] rs2_d;
        logic [HAZARD_REG_AW-1:0] rs1_e;
        logic [HAZARD_REG_AW-1:0] rs2_e;
        logic [HAZARD_REG_AW-1:0] rd_e;
        memaccess_t               memaccess_e;
        logic [HAZARD_REG_AW-1:0] rd_m;
        logic [HAZARD_REG_AW-1:0] rs2_m;
        logic                     regwrite_m;
        memaccess_t               memaccess_m;
        logic [HAZARD_REG_AW-1:0] rd_w;
        logic                     regwrite_w;
        logic                     pcsrc;
        logic                     flushflag;
    } hazard_req_t;

    typedef struct packed {
        logic [1:0]    forward_a_e;
        logic [1:0]    forward_b_e;
        logic          forward_mem_m;
        logic          stall_f;
        logic          stall_d;
        logic          flush_d;
        logic          flush_e;
        logic          flush_m;
        hazard_cause_t cause;
    } hazard_res_t;

    // x0 can never be a forwarding source, so regwrite is dropped for rd=0
    function automatic hazard_meta_t capture_meta(
        input logic [HAZARD_REG_AW-1:0] rs1,
        input logic [HAZARD_REG_AW-1:0] rs2,
        input logic [HAZARD_REG_AW-1:0] rd,
        input logic                     regwrite,
        input memaccess_t               memaccess,
        input logic                     valid
    );
        hazard_meta_t meta;
        meta.rs1       = rs1;
        meta.rs2       = rs2;
        meta.rd        = rd;
        meta.regwrite  = regwrite & valid & (rd != '0);
        meta.memaccess = valid ? memaccess : MEM_NONE;
        return meta;
    endfunction

endpackage

// File: rtl/hazard_interface.sv
// Request/response link between the hazard tracker (initiator) and the
// hazard completer that computes forwarding, stall and flush controls.
interface hazard_interface;
    import riscv_defines::*;

    hazard_req_t req;
    hazard_res_t res;

    modport initiator (output req, input res);
    modport completer (input req, output res);
endinterface

// File: rtl/hazard_stage_reg.sv
// One shadow-pipeline stage: metadata register with async reset and a
// synchronous flush that loads the bubble value.
module hazard_stage_reg
    import riscv_defines::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  hazard_meta_t d,
    output hazard_meta_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= HAZARD_BUBBLE;
        end else if (flush) begin
            q <= HAZARD_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Shadow E/M/W metadata pipeline driving hazard_bus.req and re-exporting the
// completer's controls. Optional cause counters: define HAZARD_PERF_EN.
module hazard_tracker
    import riscv_defines::*;
#(
    parameter int REG_AW = HAZARD_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic [1:0]        memaccess_d,
    input  logic              valid_d,
    input  logic              pcsrc_e,
    input  logic              flushflag,
    hazard_interface.initiator hazard_bus,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              forward_mem_m,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  cnt_raw,
    output logic [CNT_W-1:0]  cnt_store,
    output logic [CNT_W-1:0]  cnt_loaduse,
    output logic [CNT_W-1:0]  cnt_mispredict
`endif
);

    // The metadata struct width is fixed by the package
    if (CNT_W < 1 || REG_AW != HAZARD_REG_AW) begin : g_bad_params
        $error("hazard_tracker: unsupported REG_AW/CNT_W");
    end

    // Index 0 = E, 1 = M, 2 = W
    hazard_meta_t stage_d [3];
    hazard_meta_t stage_q [3];
    logic [2:0]   stage_flush;

    assign stage_d[0] = capture_meta(rs1_d, rs2_d, rd_d, regwrite_d,
                                     memaccess_t'(memaccess_d), valid_d);
    assign stage_d[1] = stage_q[0];
    assign stage_d[2] = stage_q[1];

    // Load-use stalls are realised as an E flush while D is frozen upstream
    assign stage_flush[0] = !start || hazard_bus.res.flush_e;
    assign stage_flush[1] = !start || hazard_bus.res.flush_m;
    assign stage_flush[2] = !start;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_stage
        hazard_stage_reg u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (stage_flush[gi]),
            .d     (stage_d[gi]),
            .q     (stage_q[gi])
        );
    end

    assign hazard_bus.req.rs1_d       = rs1_d;
    assign hazard_bus.req.rs2_d       = rs2_d;
    assign hazard_bus.req.rs1_e       = stage_q[0].rs1;
    assign hazard_bus.req.rs2_e       = stage_q[0].rs2;
    assign hazard_bus.req.rd_e        = stage_q[0].rd;
    assign hazard_bus.req.memaccess_e = stage_q[0].memaccess;
    assign hazard_bus.req.rd_m        = stage_q[1].rd;
    assign hazard_bus.req.rs2_m       = stage_q[1].rs2;
    assign hazard_bus.req.regwrite_m  = stage_q[1].regwrite;
    assign hazard_bus.req.memaccess_m = stage_q[1].memaccess;
    assign hazard_bus.req.rd_w        = stage_q[2].rd;
    assign hazard_bus.req.regwrite_w  = stage_q[2].regwrite;
    assign hazard_bus.req.pcsrc       = pcsrc_e;
    assign hazard_bus.req.flushflag   = flushflag;

    assign forward_a_e   = hazard_bus.res.forward_a_e;
    assign forward_b_e   = hazard_bus.res.forward_b_e;
    assign forward_mem_m = hazard_bus.res.forward_mem_m;
    assign stall_f       = hazard_bus.res.stall_f;
    assign stall_d       = hazard_bus.res.stall_d;
    assign flush_d       = hazard_bus.res.flush_d;
    assign flush_e       = hazard_bus.res.flush_e;
    assign flush_m       = hazard_bus.res.flush_m;

`ifdef HAZARD_PERF_EN
    // Bit order follows hazard_cause_t: 3 raw, 2 store, 1 loaduse, 0 mispredict
    logic [3:0] cause_vec;
    assign cause_vec = hazard_bus.res.cause;

    for (gi = 0; gi < 4; gi++) begin : g_cnt
        logic [CNT_W-1:0] count_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count_reg <= '0;
            end else if (start) begin
                count_reg <= count_reg + CNT_W'(cause_vec[gi]);
            end
        end
    end

    assign cnt_raw        = g_cnt[3].count_reg;
    assign cnt_store      = g_cnt[2].count_reg;
    assign cnt_loaduse    = g_cnt[1].count_reg;
    assign cnt_mispredict = g_cnt[0].count_reg;

    logic unused_fields;
    assign unused_fields = ^{stage_q[0].regwrite, stage_q[1].rs1, stage_q[2].rs1,
                             stage_q[2].rs2, stage_q[2].memaccess};
`else
    logic unused_fields;
    assign unused_fields = ^{stage_q[0].regwrite, stage_q[1].rs1, stage_q[2].rs1,
                             stage_q[2].rs2, stage_q[2].memaccess,
                             hazard_bus.res.cause};
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker with a small behavioural hazard completer
// on the bus; define HAZARD_PERF_EN to also check the cause counters.
module tb_hazard_tracker;
    import riscv_defines::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       regwrite_d;
    logic [1:0] memaccess_d;
    logic       valid_d;
    logic       pcsrc_e;
    logic       flushflag;
    logic [1:0] forward_a_e, forward_b_e;
    logic       forward_mem_m, stall_f, stall_d, flush_d, flush_e, flush_m;
`ifdef HAZARD_PERF_EN
    logic [31:0] cnt_raw, cnt_store, cnt_loaduse, cnt_mispredict;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic done = 1'b0;

    always #5 clk = ~clk;

    hazard_interface hz_if ();

    // Behavioural completer: forwarding compares without an rd!=0 guard, so
    // any missing x0 qualification in the tracker shows up as a forward.
    hazard_res_t res_model;
    logic        lu;
    always_comb begin
        res_model = '0;
        lu = 1'b0;
        if (hz_if.req.regwrite_m && hz_if.req.rd_m == hz_if.req.rs1_e)
            res_model.forward_a_e = FWD_M;
        else if (hz_if.req.regwrite_w && hz_if.req.rd_w == hz_if.req.rs1_e)
            res_model.forward_a_e = FWD_W;
        if (hz_if.req.regwrite_m && hz_if.req.rd_m == hz_if.req.rs2_e)
            res_model.forward_b_e = FWD_M;
        else if (hz_if.req.regwrite_w && hz_if.req.rd_w == hz_if.req.rs2_e)
            res_model.forward_b_e = FWD_W;
        res_model.forward_mem_m = (hz_if.req.memaccess_m == MEM_STORE) && hz_if.req.regwrite_w
                                  && (hz_if.req.rd_w == hz_if.req.rs2_m);
        lu = (hz_if.req.memaccess_e == MEM_LOAD) && (hz_if.req.rd_e != 5'd0)
             && (hz_if.req.rd_e == hz_if.req.rs1_d || hz_if.req.rd_e == hz_if.req.rs2_d);
        res_model.stall_f = lu;
        res_model.stall_d = lu;
        res_model.flush_d = hz_if.req.pcsrc | hz_if.req.flushflag;
        res_model.flush_e = lu | hz_if.req.pcsrc | hz_if.req.flushflag;
        res_model.flush_m = hz_if.req.flushflag;
        res_model.cause.raw        = (res_model.forward_a_e != FWD_NONE) ||
                                     (res_model.forward_b_e != FWD_NONE);
        res_model.cause.store      = res_model.forward_mem_m;
        res_model.cause.loaduse    = lu;
        res_model.cause.mispredict = hz_if.req.pcsrc;
    end
    assign hz_if.res = res_model;

    hazard_tracker #(.REG_AW(5), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .rd_d          (rd_d),
        .regwrite_d    (regwrite_d),
        .memaccess_d   (memaccess_d),
        .valid_d       (valid_d),
        .pcsrc_e       (pcsrc_e),
        .flushflag     (flushflag),
        .hazard_bus    (hz_if.initiator),
        .forward_a_e   (forward_a_e),
        .forward_b_e   (forward_b_e),
        .forward_mem_m (forward_mem_m),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .flush_m       (flush_m)
`ifdef HAZARD_PERF_EN
        ,
        .cnt_raw        (cnt_raw),
        .cnt_store      (cnt_store),
        .cnt_loaduse    (cnt_loaduse),
        .cnt_mispredict (cnt_mispredict)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s observed=%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input memaccess_t mem, input logic v);
        rs1_d       = rs1;
        rs2_d       = rs2;
        rd_d        = rd;
        regwrite_d  = rw;
        memaccess_d = mem;
        valid_d     = v;
    endtask

    task automatic nop_d();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, MEM_NONE, 1'b0);
    endtask

    initial begin
        #100000;
        if (!done) begin
            n_fail++;
            $error("FAIL timeout: wait expired before the directed sequence finished");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        pcsrc_e = 1'b0;
        flushflag = 1'b0;
        nop_d();
        #1 reset = 1'b1;
        #1;
        chk("reset_rd_e", hz_if.req.rd_e, 5'd0);
        chk("reset_regwrite_m", hz_if.req.regwrite_m, 1'b0);
        chk("reset_rd_w", hz_if.req.rd_w, 5'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        settle();
        chk("start_rd_m", hz_if.req.rd_m, 5'd0);
        chk("start_regwrite_w", hz_if.req.regwrite_w, 1'b0);
        chk("start_memaccess_e", hz_if.req.memaccess_e, MEM_NONE);
`ifdef HAZARD_PERF_EN
        chk("start_cnt_raw", cnt_raw, 32'd0);
        chk("start_cnt_mispredict", cnt_mispredict, 32'd0);
`endif

        // RAW: producer rd=5, then consumer rs1=5
        set_d(5'd1, 5'd2, 5'd5, 1'b1, MEM_NONE, 1'b1);
        tick();
        set_d(5'd5, 5'd3, 5'd6, 1'b1, MEM_NONE, 1'b1);
        settle();
        chk("raw_rd_e", hz_if.req.rd_e, 5'd5);
        tick();
        nop_d();
        settle();
        chk("raw_rd_m", hz_if.req.rd_m, 5'd5);
        chk("raw_rs1_e", hz_if.req.rs1_e, 5'd5);
        chk("raw_forward_a", forward_a_e, FWD_M);
        chk("raw_forward_b", forward_b_e, FWD_NONE);
        tick();
        settle();
        chk("raw_rd_w", hz_if.req.rd_w, 5'd5);
        chk("raw_regwrite_w", hz_if.req.regwrite_w, 1'b1);
`ifdef HAZARD_PERF_EN
        chk("raw_cnt_raw", cnt_raw, 32'd1);
`endif

        // Load-use: load rd=7, then consumer rs2=7 held in D for two cycles
        set_d(5'd1, 5'd2, 5'd7, 1'b1, MEM_LOAD, 1'b1);
        tick();
        set_d(5'd3, 5'd7, 5'd8, 1'b1, MEM_NONE, 1'b1);
        settle();
        chk("lu_stall_f", stall_f, 1'b1);
        chk("lu_stall_d", stall_d, 1'b1);
        chk("lu_flush_e", flush_e, 1'b1);
        tick();
        settle();
        chk("lu_bubble_rd_e", hz_if.req.rd_e, 5'd0);
        chk("lu_stall_released", stall_d, 1'b0);
        chk("lu_rd_m", hz_if.req.rd_m, 5'd7);
        chk("lu_memaccess_m", hz_if.req.memaccess_m, MEM_LOAD);
        tick();
        nop_d();
        settle();
        chk("lu_rs2_e", hz_if.req.rs2_e, 5'd7);
        chk("lu_rd_e", hz_if.req.rd_e, 5'd8);
        chk("lu_forward_b_w", forward_b_e, FWD_W);
        tick();

        // Mispredict: taken branch in E kills the instruction entering E
        set_d(5'd1, 5'd2, 5'd9, 1'b1, MEM_NONE, 1'b1);
        tick();
        set_d(5'd4, 5'd4, 5'd10, 1'b1, MEM_STORE, 1'b1);
        pcsrc_e = 1'b1;
        settle();
        chk("mp_flush_d", flush_d, 1'b1);
        chk("mp_flush_e", flush_e, 1'b1);
        chk("mp_flush_m", flush_m, 1'b0);
        tick();
        pcsrc_e = 1'b0;
        nop_d();
        settle();
        chk("mp_rd_e", hz_if.req.rd_e, 5'd0);
        chk("mp_memaccess_e", hz_if.req.memaccess_e, MEM_NONE);
        chk("mp_rd_m", hz_if.req.rd_m, 5'd9);
`ifdef HAZARD_PERF_EN
        chk("mp_cnt_mispredict", cnt_mispredict, 32'd1);
`endif

        // x0 destination never becomes a forwarding source
        set_d(5'd1, 5'd2, 5'd0, 1'b1, MEM_NONE, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 5'd11, 1'b1, MEM_NONE, 1'b1);
        tick();
        nop_d();
        settle();
        chk("x0_regwrite_m", hz_if.req.regwrite_m, 1'b0);
        chk("x0_forward_a", forward_a_e, FWD_NONE);
        chk("x0_forward_b", forward_b_e, FWD_NONE);
        tick();

        // flushflag together with load-use: E and M bubble, W takes old M
        set_d(5'd1, 5'd2, 5'd12, 1'b1, MEM_NONE, 1'b1);
        tick();
        set_d(5'd1, 5'd2, 5'd13, 1'b1, MEM_LOAD, 1'b1);
        tick();
        set_d(5'd13, 5'd0, 5'd14, 1'b1, MEM_NONE, 1'b1);
        flushflag = 1'b1;
        settle();
        chk("ff_stall_d", stall_d, 1'b1);
        chk("ff_flush_m", flush_m, 1'b1);
        tick();
        flushflag = 1'b0;
        nop_d();
        settle();
        chk("ff_rd_e", hz_if.req.rd_e, 5'd0);
        chk("ff_rd_m", hz_if.req.rd_m, 5'd0);
        chk("ff_memaccess_m", hz_if.req.memaccess_m, MEM_NONE);
        chk("ff_rd_w", hz_if.req.rd_w, 5'd12);
        chk("ff_regwrite_w", hz_if.req.regwrite_w, 1'b1);

        // Store data forwarded from W into M
        set_d(5'd1, 5'd2, 5'd15, 1'b1, MEM_NONE, 1'b1);
        tick();
        set_d(5'd1, 5'd15, 5'd0, 1'b0, MEM_STORE, 1'b1);
        tick();
        nop_d();
        settle();
        chk("st_forward_b_m", forward_b_e, FWD_M);
        tick();
        settle();
        chk("st_rs2_m", hz_if.req.rs2_m, 5'd15);
        chk("st_forward_mem", forward_mem_m, 1'b1);
        tick();
        settle();
`ifdef HAZARD_PERF_EN
        chk("end_cnt_raw", cnt_raw, 32'd3);
        chk("end_cnt_store", cnt_store, 32'd1);
        chk("end_cnt_loaduse", cnt_loaduse, 32'd2);
        chk("end_cnt_mispredict", cnt_mispredict, 32'd1);
`endif

        // Asynchronous reset mid-operation clears stages without a clock edge
        set_d(5'd1, 5'd2, 5'd20, 1'b1, MEM_NONE, 1'b1);
        tick();
        settle();
        chk("mid_rd_e_before", hz_if.req.rd_e, 5'd20);
        reset = 1'b1;
        #1;
        chk("mid_rd_e_after", hz_if.req.rd_e, 5'd0);
`ifdef HAZARD_PERF_EN
        chk("mid_cnt_raw", cnt_raw, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        tick();

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
